// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types and default constants for the scanner pair and
//               the scan scheduler (scanner state codes, scheduler FSM
//               states, fill thresholds and wait limit).
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Scanner state codes, shared with the scanner modules
    typedef enum logic [2:0] {
        LOW_PWR  = 3'd0,
        STBY     = 3'd1,
        SCANNING = 3'd2,
        IDLE     = 3'd3,
        FLUSHING = 3'd4
    } scan_state_e;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        RUN   = 3'd0,
        WAKE  = 3'd1,
        START = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4
    } sched_state_e;

    // Default thresholds (fill in percent) and wait-state limit (cycles)
    localparam logic [7:0]  c_stby_thresh_dflt = 8'd90;
    localparam logic [7:0]  c_rdy_thresh_dflt  = 8'd80;
    localparam int unsigned c_timeout_dflt     = 200;

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : Wait-state cycle counter. Clears on request, counts while
//               enabled, and flags the cycle whose increment would reach
//               TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer
    import scan_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_timeout_dflt
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned c_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT - 1);
    localparam logic [c_w-1:0] c_one  = c_w'(1);

    logic [c_w-1:0] r_count;

    // Expiry fires on the enabled cycle that completes TIMEOUT counted cycles,
    // so the owner leaves the wait state after exactly TIMEOUT cycles.
    assign expired = enable && (r_count == c_last);

    // Count enabled cycles; restart from zero on clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : scan_scheduler
// Description : Sequencing controller for the primary/alternate scanner
//               pair. Hands scan duty from the filling scanner (A) to the
//               dormant one (B) and grants the shared downlink flush to A.
//               FSM logic is written once against A/B and muxed by active.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_scheduler
    import scan_pkg::*;
#(
    parameter logic [7:0]  STBY_THRESH = c_stby_thresh_dflt,
    parameter logic [7:0]  RDY_THRESH  = c_rdy_thresh_dflt,
    parameter int unsigned TIMEOUT     = c_timeout_dflt
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  prim_state,
    input  logic [2:0]  alt_state,
    input  logic [7:0]  prim_mem_used,
    input  logic [7:0]  alt_mem_used,
    input  logic        link_busy,
    output logic        prim_goto_stby,
    output logic        alt_goto_stby,
    output logic        prim_start_scan,
    output logic        alt_start_scan,
    output logic        prim_flush,
    output logic        alt_flush,
    output logic        active,
    output logic [15:0] flush_count,
    output logic        error
);

    sched_state_e r_state;
    sched_state_e w_next;

    logic [2:0]  w_a_state;
    logic [2:0]  w_b_state;
    logic [7:0]  w_a_mem;

    logic        w_goto_b;
    logic        w_start_b;
    logic        w_flush_a;
    logic        w_done;
    logic        w_timeout;
    logic        w_grant;

    logic        w_clear;
    logic        w_enable;
    logic        w_expired;

    logic        r_active;
    logic        r_prim_goto;
    logic        r_alt_goto;
    logic        r_prim_start;
    logic        r_alt_start;
    logic        r_prim_flush;
    logic        r_alt_flush;
    logic [15:0] r_flush_count;
    logic        r_error;

    // A is the scanner owning scan duty, B the other one
    assign w_a_state = r_active ? alt_state     : prim_state;
    assign w_b_state = r_active ? prim_state    : alt_state;
    assign w_a_mem   = r_active ? alt_mem_used  : prim_mem_used;

    // Flush is legal from scanning or from idle (a full scanner parks in idle)
    assign w_grant = (w_a_mem >= RDY_THRESH) && !link_busy &&
                     ((w_a_state == SCANNING) || (w_a_state == IDLE));

    // Timer restarts on every state change; a busy link in DRAIN is not
    // counted against the wait limit.
    assign w_clear  = (w_next != r_state);
    assign w_enable = (r_state != RUN) && !((r_state == DRAIN) && link_busy);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .enable  (w_enable),
        .expired (w_expired)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and A/B action decode; timeout takes priority in wait states
    always_comb begin
        w_next    = r_state;
        w_goto_b  = 1'b0;
        w_start_b = 1'b0;
        w_flush_a = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            RUN: begin
                if ((w_a_mem >= STBY_THRESH) && (w_b_state == LOW_PWR)) begin
                    w_goto_b = 1'b1;
                    w_next   = WAKE;
                end
            end
            WAKE: begin
                if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = RUN;
                end else if (w_b_state == STBY) begin
                    w_start_b = 1'b1;
                    w_next    = START;
                end
            end
            START: begin
                if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = RUN;
                end else if (w_b_state == SCANNING) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = RUN;
                end else if (w_a_state == FLUSHING) begin
                    // A started an auto-flush on its own: treat as granted
                    w_next = FLUSH;
                end else if (w_grant) begin
                    w_flush_a = 1'b1;
                    w_next    = FLUSH;
                end
            end
            FLUSH: begin
                if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = RUN;
                end else if (w_a_state == LOW_PWR) begin
                    w_done = 1'b1;
                    w_next = RUN;
                end
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    // Registered pulses steered to prim/alt, plus ownership, count and error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active      <= 1'b0;
            r_prim_goto   <= 1'b0;
            r_alt_goto    <= 1'b0;
            r_prim_start  <= 1'b0;
            r_alt_start   <= 1'b0;
            r_prim_flush  <= 1'b0;
            r_alt_flush   <= 1'b0;
            r_flush_count <= 16'd0;
            r_error       <= 1'b0;
        end else begin
            r_prim_goto  <= w_goto_b  &  r_active;
            r_alt_goto   <= w_goto_b  & ~r_active;
            r_prim_start <= w_start_b &  r_active;
            r_alt_start  <= w_start_b & ~r_active;
            r_prim_flush <= w_flush_a & ~r_active;
            r_alt_flush  <= w_flush_a &  r_active;
            if (w_done) begin
                r_active      <= ~r_active;
                r_flush_count <= r_flush_count + 16'd1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign prim_goto_stby  = r_prim_goto;
    assign alt_goto_stby   = r_alt_goto;
    assign prim_start_scan = r_prim_start;
    assign alt_start_scan  = r_alt_start;
    assign prim_flush      = r_prim_flush;
    assign alt_flush       = r_alt_flush;
    assign active          = r_active;
    assign flush_count     = r_flush_count;
    assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_scheduler
// Description : Self-checking bench for scan_scheduler. Cycle vectors with
//               expected outputs are queued as a scoreboard and compared one
//               cycle later; long busy/timeout/auto-flush cases are
//               hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_scheduler;
    import scan_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  prim_state;
    logic [2:0]  alt_state;
    logic [7:0]  prim_mem_used;
    logic [7:0]  alt_mem_used;
    logic        link_busy;
    logic        prim_goto_stby;
    logic        alt_goto_stby;
    logic        prim_start_scan;
    logic        alt_start_scan;
    logic        prim_flush;
    logic        alt_flush;
    logic        active;
    logic [15:0] flush_count;
    logic        error;
    logic [5:0]  pulses;

    scan_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .prim_state      (prim_state),
        .alt_state       (alt_state),
        .prim_mem_used   (prim_mem_used),
        .alt_mem_used    (alt_mem_used),
        .link_busy       (link_busy),
        .prim_goto_stby  (prim_goto_stby),
        .alt_goto_stby   (alt_goto_stby),
        .prim_start_scan (prim_start_scan),
        .alt_start_scan  (alt_start_scan),
        .prim_flush      (prim_flush),
        .alt_flush       (alt_flush),
        .active          (active),
        .flush_count     (flush_count),
        .error           (error)
    );

    always #5 clk = ~clk;

    assign pulses = {prim_goto_stby, alt_goto_stby, prim_start_scan,
                     alt_start_scan, prim_flush, alt_flush};

    typedef struct {
        logic        rst;
        logic [2:0]  ps;
        logic [2:0]  as;
        logic [7:0]  pm;
        logic [7:0]  am;
        logic        busy;
        logic [5:0]  pulses;
        logic        act;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    typedef struct {
        logic [5:0]  pulses;
        logic        act;
        logic [15:0] cnt;
        logic        err;
        int          idx;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic        m_active;
    logic [15:0] m_cnt;

    // Pulse codes as seen from A/B, bit order {pg, ag, ps, as, pf, af}
    function automatic logic [5:0] p_goto(input logic a);
        return a ? 6'b100000 : 6'b010000;
    endfunction
    function automatic logic [5:0] p_start(input logic a);
        return a ? 6'b001000 : 6'b000100;
    endfunction
    function automatic logic [5:0] p_flush(input logic a);
        return a ? 6'b000001 : 6'b000010;
    endfunction

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    // Append one vector, inputs given as A/B and mapped to prim/alt
    task automatic add(input logic rst, input logic a,
                       input logic [2:0] a_st, input logic [7:0] a_mem,
                       input logic [2:0] b_st, input logic [7:0] b_mem,
                       input logic busy, input logic [5:0] exp_p);
        vec_t v;
        v.rst    = rst;
        v.ps     = a ? b_st  : a_st;
        v.pm     = a ? b_mem : a_mem;
        v.as     = a ? a_st  : b_st;
        v.am     = a ? a_mem : b_mem;
        v.busy   = busy;
        v.pulses = exp_p;
        v.act    = m_active;
        v.cnt    = m_cnt;
        v.err    = 1'b0;
        vecs.push_back(v);
    endtask

    // One handoff with single-cycle scanner responses
    task automatic add_handoff(input bit bnd, input bit fin);
        logic a;
        a = m_active;
        add(1'b0, a, SCANNING, 8'd89,  LOW_PWR,  8'd10, 1'b0, 6'b0);
        add(1'b0, a, SCANNING, 8'd90,  LOW_PWR,  8'd10, 1'b0, p_goto(a));
        add(1'b0, a, SCANNING, 8'd92,  STBY,     8'd0,  1'b0, p_start(a));
        add(1'b0, a, SCANNING, 8'd95,  SCANNING, 8'd0,  1'b0, 6'b0);
        if (bnd) add(1'b0, a, SCANNING, 8'd79, SCANNING, 8'd1, 1'b0, 6'b0);
        add(1'b0, a, IDLE,     8'd100, SCANNING, 8'd2,  1'b0, p_flush(a));
        add(1'b0, a, FLUSHING, 8'd100, SCANNING, 8'd3,  1'b0, 6'b0);
        if (fin) begin
            m_active = ~a;
            m_cnt    = m_cnt + 16'd1;
            add(1'b0, a, LOW_PWR, 8'd0, SCANNING, 8'd10, 1'b0, 6'b0);
        end
    endtask

    task automatic drv(input logic a,
                       input logic [2:0] a_st, input logic [7:0] a_mem,
                       input logic [2:0] b_st, input logic [7:0] b_mem,
                       input logic busy);
        prim_state    = a ? b_st  : a_st;
        prim_mem_used = a ? b_mem : a_mem;
        alt_state     = a ? a_st  : b_st;
        alt_mem_used  = a ? a_mem : b_mem;
        link_busy     = busy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        drv(1'b0, SCANNING, 8'd0, LOW_PWR, 8'd0, 1'b0);

        // ---------------- vector table ----------------
        m_active = 1'b0;
        m_cnt    = 16'd0;
        add(1'b1, 1'b0, SCANNING, 8'd0,  LOW_PWR, 8'd0, 1'b0, 6'b0);
        add(1'b0, 1'b0, SCANNING, 8'd50, LOW_PWR, 8'd0, 1'b0, 6'b0);
        add_handoff(1'b0, 1'b1);   // prim -> alt, minimum latency
        add_handoff(1'b1, 1'b1);   // alt -> prim, with 79% boundary
        add_handoff(1'b0, 1'b0);   // stop in FLUSH
        m_active = 1'b0;
        m_cnt    = 16'd0;
        add(1'b1, 1'b0, LOW_PWR,  8'd0,  SCANNING, 8'd10, 1'b0, 6'b0);
        add(1'b0, 1'b0, SCANNING, 8'd10, LOW_PWR,  8'd0,  1'b0, 6'b0);
        add_handoff(1'b0, 1'b1);
        add_handoff(1'b0, 1'b1);

        foreach (vecs[i]) begin
            reset         = vecs[i].rst;
            prim_state    = vecs[i].ps;
            alt_state     = vecs[i].as;
            prim_mem_used = vecs[i].pm;
            alt_mem_used  = vecs[i].am;
            link_busy     = vecs[i].busy;
            sb.push_back('{pulses: vecs[i].pulses, act: vecs[i].act,
                           cnt: vecs[i].cnt, err: vecs[i].err, idx: i});
            step();
            e = sb.pop_front();
            chk($sformatf("vec%0d pulses", e.idx), 32'(pulses), 32'(e.pulses));
            chk($sformatf("vec%0d active", e.idx), 32'(active), 32'(e.act));
            chk($sformatf("vec%0d count", e.idx), 32'(flush_count), 32'(e.cnt));
            chk($sformatf("vec%0d error", e.idx), 32'(error), 32'(e.err));
        end
        reset = 1'b0;

        // ---------------- link busy for 500 cycles in DRAIN (active=0, count=2) ----------------
        drv(1'b0, SCANNING, 8'd90, LOW_PWR, 8'd0, 1'b0);  step();
        chk("busy goto", 32'(pulses), 32'(p_goto(1'b0)));
        drv(1'b0, SCANNING, 8'd90, STBY, 8'd0, 1'b0);     step();
        chk("busy start", 32'(pulses), 32'(p_start(1'b0)));
        drv(1'b0, SCANNING, 8'd95, SCANNING, 8'd0, 1'b0); step();
        drv(1'b0, IDLE, 8'd100, SCANNING, 8'd10, 1'b1);
        for (int k = 0; k < 500; k++) begin
            step();
            chk("busy hold pulses", 32'(pulses), 32'd0);
        end
        chk("busy hold error", 32'(error), 32'd0);
        drv(1'b0, IDLE, 8'd100, SCANNING, 8'd10, 1'b0);   step();
        chk("busy release flush", 32'(pulses), 32'(p_flush(1'b0)));
        drv(1'b0, FLUSHING, 8'd100, SCANNING, 8'd10, 1'b0); step();
        drv(1'b0, LOW_PWR, 8'd0, SCANNING, 8'd10, 1'b0);  step();
        chk("busy done active", 32'(active), 32'd1);
        chk("busy done count", 32'(flush_count), 32'd3);

        // ---------------- auto-flush from idle in DRAIN (active=1) ----------------
        drv(1'b1, SCANNING, 8'd90, LOW_PWR, 8'd0, 1'b0);  step();
        chk("auto goto", 32'(pulses), 32'(p_goto(1'b1)));
        drv(1'b1, SCANNING, 8'd90, STBY, 8'd0, 1'b0);     step();
        chk("auto start", 32'(pulses), 32'(p_start(1'b1)));
        drv(1'b1, SCANNING, 8'd95, SCANNING, 8'd50, 1'b1); step();
        drv(1'b1, IDLE, 8'd100, SCANNING, 8'd50, 1'b1);   step();
        chk("auto idle pulses", 32'(pulses), 32'd0);
        drv(1'b1, FLUSHING, 8'd100, SCANNING, 8'd50, 1'b1); step();
        chk("auto flushing pulses", 32'(pulses), 32'd0);
        drv(1'b1, FLUSHING, 8'd100, SCANNING, 8'd50, 1'b0); step();
        chk("auto in flush pulses", 32'(pulses), 32'd0);
        chk("auto in flush count", 32'(flush_count), 32'd3);
        drv(1'b1, LOW_PWR, 8'd0, SCANNING, 8'd50, 1'b0);  step();
        chk("auto done count", 32'(flush_count), 32'd4);
        chk("auto done active", 32'(active), 32'd0);
        drv(1'b0, SCANNING, 8'd10, LOW_PWR, 8'd0, 1'b0);  step();
        chk("auto count once", 32'(flush_count), 32'd4);
        chk("auto run pulses", 32'(pulses), 32'd0);

        // ---------------- B stuck in low_pwr: timeout ----------------
        drv(1'b0, SCANNING, 8'd90, LOW_PWR, 8'd0, 1'b0);  step();
        chk("to goto", 32'(pulses), 32'(p_goto(1'b0)));
        for (int k = 1; k < 200; k++) begin
            step();
            chk("to wait pulses", 32'(pulses), 32'd0);
            chk("to wait error", 32'(error), 32'd0);
        end
        step();
        chk("to error", 32'(error), 32'd1);
        chk("to active", 32'(active), 32'd0);
        chk("to count", 32'(flush_count), 32'd4);
        chk("to pulses", 32'(pulses), 32'd0);
        step();
        chk("to back in run goto", 32'(pulses), 32'(p_goto(1'b0)));
        chk("to error sticky", 32'(error), 32'd1);
        reset = 1'b1;
        step();
        chk("rst error", 32'(error), 32'd0);
        chk("rst active", 32'(active), 32'd0);
        chk("rst count", 32'(flush_count), 32'd0);
        chk("rst pulses", 32'(pulses), 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_scheduler.md
# scan_scheduler

Sequencing controller for the primary/alternate scanner pair. Watches both scanners' state and memory fill, hands scanning duty from the filling scanner to the dormant one, and grants the single shared downlink for flushing, one scanner at a time. Sits above the two scanner instances and drives their `start_scan_in`, `goto_stby_in` and `flush` inputs.

## Interface
- `STBY_THRESH`, 90: active-scanner fill (percent) at which handoff begins.
- `RDY_THRESH`, 80: minimum fill before a flush may be granted.
- `TIMEOUT`, 200: maximum cycles spent in any wait state.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `prim_state`, `alt_state`  in  3 each  scanner state: 0 low_pwr, 1 stby, 2 scanning, 3 idle, 4 flushing.
- `prim_mem_used`, `alt_mem_used`  in  8 each  scanner fill, 0–100.
- `link_busy`  in  1  shared downlink unavailable; no flush grant while high.
- `prim_goto_stby`, `alt_goto_stby`  out  1 each  one-cycle pulse, wake scanner to stby.
- `prim_start_scan`, `alt_start_scan`  out  1 each  one-cycle pulse, stby to scanning.
- `prim_flush`, `alt_flush`  out  1 each  one-cycle flush grant.
- `active`  out  1  scanner currently owning scan duty: 0 prim, 1 alt.
- `flush_count`  out  16  completed flushes, wraps at 65535→0.
- `error`  out  1  sticky, set on any wait-state timeout.

## Operation
- FSM states: RUN, WAKE, START, DRAIN, FLUSH.
- Notation: A = scanner indexed by `active`; B = the other scanner.
- RUN: idle monitoring. When A.mem_used ≥ STBY_THRESH and B.state == low_pwr, pulse B.goto_stby and go to WAKE.
- WAKE: when B.state == stby, pulse B.start_scan and go to START.
- START: when B.state == scanning, go to DRAIN.
- DRAIN:
  - Grant condition: A.mem_used ≥ RDY_THRESH, A.state ∈ {scanning, idle}, and link_busy == 0.
  - When the grant condition holds, pulse A.flush and go to FLUSH.
  - If link_busy is high, hold in DRAIN. A may reach idle at 100; the grant is still legal from idle.
- FLUSH: when A.state == low_pwr, increment flush_count, toggle `active`, and go to RUN.
- Timeout:
  - The wait counter clears on every state entry and increments each cycle in WAKE, START, DRAIN and FLUSH.
  - In DRAIN, the counter holds while link_busy is high, so a busy link is not an error.
  - When the counter reaches TIMEOUT: set `error`, return to RUN, and leave `active` and `flush_count` unchanged.
- A scanner that auto-flushes (idle and the other scanner's fill > 49) during DRAIN is treated as granted. If A.state == flushing is observed in DRAIN, go to FLUSH without pulsing A.flush.
- At most one of the six pulse outputs is high in any cycle.
- Never pulse to A any output other than flush. Never flush B.

## Timing
- Reset values:
  - FSM state: RUN.
  - `active`: 0.
  - All pulse outputs: 0.
  - `flush_count`: 0.
  - `error`: 0.
  - Wait counter: 0.
- `error` clears only on reset.
- Every pulse output is registered and high for exactly the one cycle after the transition condition is sampled true.
- Condition sampled at edge n → pulse high during cycle n+1, FSM already in the next state.
- Minimum handoff, if each scanner responds in one cycle: RUN→WAKE→START→DRAIN→FLUSH. The flush grant is issued 3 cycles after the threshold is detected.
- flush_count increments and `active` toggles on the same edge that FSM enters RUN from FLUSH.
- Reset mid-operation: all registers return to reset values on the next edge. In-flight pulses are dropped.
- Comparisons are unsigned 8-bit. Inputs above 100 are treated as full (≥ both thresholds).

## Structure
- Package `scan_pkg` holds:
  - the scanner state enum (`LOW_PWR`=0, `STBY`=1, `SCANNING`=2, `IDLE`=3, `FLUSHING`=4), shared with the scanner modules;
  - the scheduler FSM enum;
  - default threshold constants.
- One sub-module, `wait_timer`:
  - Inputs: `clear`, `enable`. Output: `expired`.
  - Width derived from `TIMEOUT` with `$clog2`.
- Prim/alt port pairs are muxed internally by `active`. The FSM logic is written once, against A/B.

## Test plan
- Reset, prim mem ramps 0→90, alt low_pwr → alt_goto_stby pulses for exactly 1 cycle; FSM in WAKE; `active`=0.
- Full handoff with one-cycle scanner responses → alt_start_scan, then prim_flush 3 cycles after threshold; prim reaches low_pwr → `active`=1, `flush_count`=1.
- link_busy high for 500 cycles in DRAIN, prim mem at 100/idle → no prim_flush and `error` stays 0; link_busy drops → prim_flush next cycle.
- alt stuck in low_pwr after goto_stby → after 200 cycles `error`=1, FSM in RUN, `active`=0, `flush_count`=0.
- Prim auto-flushes from idle in DRAIN (alt mem 50) → no prim_flush pulse; FSM reaches FLUSH; count increments once on low_pwr.
- Reset asserted in FLUSH → next cycle all outputs 0, `active`=0, `flush_count`=0; two back-to-back handoffs after release → `active` 0→1→0, `flush_count`=2.
